// File: rtl/lmu_pchscan_pkg.sv
// lmu_pchscan_pkg
// Shared constants for the patch scanner: patch/qubit geometry, scanner
// state encodings, Pauli-frame bit offsets and the Pauli-frame selection
// helper. Geometry values mirror define.v for the rest of the LMU.
// Optional feature macro used by the scanner files: LMU_PCHSKIP_EN.
package lmu_pchscan_pkg;

    localparam int NUM_PCH    = 4;
    localparam int PCHADDR_BW = 2;
    localparam int NUM_PCHDQ  = 4;
    localparam int NUM_PCHAQ  = 3;

    // Scanner state encodings
    localparam logic [1:0] LMU_PCHSCAN_IDLE = 2'd0;
    localparam logic [1:0] LMU_PCHSCAN_SCAN = 2'd1;
    localparam logic [1:0] LMU_PCHSCAN_DONE = 2'd2;

    // Offsets of the flip bits inside each 2-bit Pauli-frame pair
    localparam int PF_XBIT = 0;
    localparam int PF_ZBIT = 1;

    // A Z-basis readout is corrupted by X flips, an X-basis readout by Z
    // flips, so pick the matching flip bit for every data qubit.
    function automatic logic [NUM_PCHDQ-1:0] pf_select(
        input logic [2*NUM_PCHDQ-1:0] pf,
        input logic                   z_basis
    );
        logic [NUM_PCHDQ-1:0] sel;
        for (int i = 0; i < NUM_PCHDQ; i++) begin
            sel[i] = z_basis ? pf[2*i+PF_XBIT] : pf[2*i+PF_ZBIT];
        end
        return sel;
    endfunction

endpackage

// File: rtl/lmu_pchscan_if.sv
// lmu_pchscan_if
// Bundles the scanner's measurement-side handshake, the lmu_measmux
// select/slice signals and the result-side handshake.
//   master : the scanner (drives meas_ready, pchidx, results, result_valid)
//   slave  : the surrounding LMU logic / mux / result consumer
// With LMU_PCHSKIP_EN defined the per-patch pch_active mask is added.
interface lmu_pchscan_if;
    import lmu_pchscan_pkg::*;

    logic                    meas_valid;
    logic                    meas_ready;
    logic [NUM_PCH-1:0]      pch_basis;
`ifdef LMU_PCHSKIP_EN
    logic [NUM_PCH-1:0]      pch_active;
`endif
    logic [PCHADDR_BW-1:0]   pchidx;
    logic [NUM_PCHDQ-1:0]    dqmeas_array_pch;
    logic [NUM_PCHAQ-1:0]    aqmeas_array_pch;
    logic [2*NUM_PCHDQ-1:0]  pf_array_pch;
    logic [NUM_PCH-1:0]      pchmeas_result;
    logic [NUM_PCH-1:0]      pchsyn_flag;
    logic                    result_valid;
    logic                    result_ready;

    modport master (
        input  meas_valid,
        output meas_ready,
        input  pch_basis,
`ifdef LMU_PCHSKIP_EN
        input  pch_active,
`endif
        output pchidx,
        input  dqmeas_array_pch,
        input  aqmeas_array_pch,
        input  pf_array_pch,
        output pchmeas_result,
        output pchsyn_flag,
        output result_valid,
        input  result_ready
    );

    modport slave (
        output meas_valid,
        input  meas_ready,
        output pch_basis,
`ifdef LMU_PCHSKIP_EN
        output pch_active,
`endif
        input  pchidx,
        output dqmeas_array_pch,
        output aqmeas_array_pch,
        output pf_array_pch,
        input  pchmeas_result,
        input  pchsyn_flag,
        input  result_valid,
        output result_ready
    );

endinterface

// File: rtl/lmu_nextpch.sv
// lmu_nextpch
// Combinational priority encoder used by the scanner when patch skipping
// (LMU_PCHSKIP_EN) is built in. Returns the lowest active patch index that
// lies above cur_idx (or at cur_idx when incl_cur is set).
//   mask      in  NUM_PCH     active-patch mask
//   cur_idx   in  PCHADDR_BW  search start point
//   incl_cur  in  1           1 = cur_idx itself is a candidate
//   next_idx  out PCHADDR_BW  next active patch (0 when none)
//   none_left out 1           no active patch found
module lmu_nextpch
    import lmu_pchscan_pkg::*;
(
    input  logic [NUM_PCH-1:0]    mask,
    input  logic [PCHADDR_BW-1:0] cur_idx,
    input  logic                  incl_cur,
    output logic [PCHADDR_BW-1:0] next_idx,
    output logic                  none_left
);

    // Walk from the top down so the last hit written is the lowest index.
    always_comb begin
        next_idx  = '0;
        none_left = 1'b1;
        for (int i = NUM_PCH - 1; i >= 0; i--) begin
            if (mask[i] && ((PCHADDR_BW'(i) > cur_idx) ||
                            (incl_cur && (PCHADDR_BW'(i) == cur_idx)))) begin
                next_idx  = PCHADDR_BW'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lmu_pchscan.sv
// lmu_pchscan
// Steps pchidx over the patches after a measurement round, sampling the
// combinational lmu_measmux slice for the selected patch every cycle. Per
// patch it records the Pauli-frame-corrected logical outcome (dq parity)
// and a syndrome-nonzero flag, then offers both arrays on a valid/ready
// handshake.
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    lmu_pchscan_if.master: meas_valid/meas_ready, pch_basis,
//          pchidx, dq/aq/pf slices, pchmeas_result, pchsyn_flag,
//          result_valid/result_ready
// Optional feature: LMU_PCHSKIP_EN adds pch_active and skips inactive
// patches using lmu_nextpch.
module lmu_pchscan
    import lmu_pchscan_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    lmu_pchscan_if.master bus
);

    logic [1:0]            state_q,  state_d;
    logic [PCHADDR_BW-1:0] pchidx_q, pchidx_d;
    logic [NUM_PCH-1:0]    basis_q,  basis_d;
    logic [NUM_PCH-1:0]    result_q, result_d;
    logic [NUM_PCH-1:0]    syn_q,    syn_d;
    logic [NUM_PCHDQ-1:0]  pf_sel;

`ifdef LMU_PCHSKIP_EN
    logic [NUM_PCH-1:0]    active_q, active_d;
    logic [NUM_PCH-1:0]    nx_mask;
    logic [PCHADDR_BW-1:0] nx_cur;
    logic                  nx_incl;
    logic [PCHADDR_BW-1:0] nx_idx;
    logic                  nx_none;

    // At accept the search starts from patch 0 on the incoming mask; during
    // the scan it looks strictly above the patch being sampled right now.
    always_comb begin
        if (state_q == LMU_PCHSCAN_IDLE) begin
            nx_mask = bus.pch_active;
            nx_cur  = '0;
            nx_incl = 1'b1;
        end else begin
            nx_mask = active_q;
            nx_cur  = pchidx_q;
            nx_incl = 1'b0;
        end
    end

    lmu_nextpch u_nextpch (
        .mask      (nx_mask),
        .cur_idx   (nx_cur),
        .incl_cur  (nx_incl),
        .next_idx  (nx_idx),
        .none_left (nx_none)
    );
`endif

    // Next-state logic. Result arrays are only cleared at accept, so they
    // hold through DONE and the following IDLE.
    always_comb begin
        state_d  = state_q;
        pchidx_d = pchidx_q;
        basis_d  = basis_q;
        result_d = result_q;
        syn_d    = syn_q;
`ifdef LMU_PCHSKIP_EN
        active_d = active_q;
`endif
        pf_sel = pf_select(bus.pf_array_pch, basis_q[pchidx_q]);

        case (state_q)
            LMU_PCHSCAN_IDLE: begin
                if (bus.meas_valid) begin
                    basis_d  = bus.pch_basis;
                    result_d = '0;
                    syn_d    = '0;
`ifdef LMU_PCHSKIP_EN
                    active_d = bus.pch_active;
                    pchidx_d = nx_none ? '0 : nx_idx;
                    state_d  = nx_none ? LMU_PCHSCAN_DONE : LMU_PCHSCAN_SCAN;
`else
                    pchidx_d = '0;
                    state_d  = LMU_PCHSCAN_SCAN;
`endif
                end
            end

            LMU_PCHSCAN_SCAN: begin
                result_d[pchidx_q] = ^(bus.dqmeas_array_pch ^ pf_sel);
                syn_d[pchidx_q]    = |bus.aqmeas_array_pch;
`ifdef LMU_PCHSKIP_EN
                if (nx_none) begin
                    state_d = LMU_PCHSCAN_DONE;
                end else begin
                    pchidx_d = nx_idx;
                end
`else
                // pchidx stops on the last patch rather than wrapping, so
                // non-power-of-two patch counts need no special case.
                if (pchidx_q == PCHADDR_BW'(NUM_PCH - 1)) begin
                    state_d = LMU_PCHSCAN_DONE;
                end else begin
                    pchidx_d = pchidx_q + 1'b1;
                end
`endif
            end

            LMU_PCHSCAN_DONE: begin
                if (bus.result_ready) begin
                    state_d  = LMU_PCHSCAN_IDLE;
                    pchidx_d = '0;
                end
            end

            default: begin
                state_d  = LMU_PCHSCAN_IDLE;
                pchidx_d = '0;
            end
        endcase
    end

    // State registers; reset aborts any scan in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LMU_PCHSCAN_IDLE;
            pchidx_q <= '0;
            basis_q  <= '0;
            result_q <= '0;
            syn_q    <= '0;
`ifdef LMU_PCHSKIP_EN
            active_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pchidx_q <= pchidx_d;
            basis_q  <= basis_d;
            result_q <= result_d;
            syn_q    <= syn_d;
`ifdef LMU_PCHSKIP_EN
            active_q <= active_d;
`endif
        end
    end

    // Handshake outputs are plain decodes of the registered state.
    assign bus.meas_ready     = (state_q == LMU_PCHSCAN_IDLE);
    assign bus.result_valid   = (state_q == LMU_PCHSCAN_DONE);
    assign bus.pchidx         = pchidx_q;
    assign bus.pchmeas_result = result_q;
    assign bus.pchsyn_flag    = syn_q;

endmodule

// File: tb/tb_lmu_pchscan.sv
// tb_lmu_pchscan
// Directed bench for lmu_pchscan with NUM_PCH=4, NUM_PCHDQ=4, NUM_PCHAQ=3.
// A small table-driven model of lmu_measmux feeds the slices selected by
// pchidx. Outputs are sampled on the falling clock edge.
// With LMU_PCHSKIP_EN defined the patch-skip scenarios are also run.
module tb_lmu_pchscan;
    import lmu_pchscan_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    logic [NUM_PCHDQ-1:0]   dq_tab [NUM_PCH];
    logic [NUM_PCHAQ-1:0]   aq_tab [NUM_PCH];
    logic [2*NUM_PCHDQ-1:0] pf_tab [NUM_PCH];

    lmu_pchscan_if bus ();

    lmu_pchscan dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model of lmu_measmux: the slice for the selected patch, combinationally.
    always_comb begin
        bus.dqmeas_array_pch = dq_tab[bus.pchidx];
        bus.aqmeas_array_pch = aq_tab[bus.pchidx];
        bus.pf_array_pch     = pf_tab[bus.pchidx];
    end

    // Loads all four patches; patch p sits at the p-th field of each word.
    task automatic loadTables(input logic [15:0] dq, input logic [11:0] aq,
                              input logic [31:0] pf);
        for (int p = 0; p < 4; p++) begin
            dq_tab[p] = dq[p*4 +: 4];
            aq_tab[p] = aq[p*3 +: 3];
            pf_tab[p] = pf[p*8 +: 8];
        end
    endtask

    task automatic applyStimulus(input logic mv, input logic [3:0] basis,
                                 input logic rr);
        bus.meas_valid   = mv;
        bus.pch_basis    = basis;
        bus.result_ready = rr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Idle-state view after a handshake back to IDLE.
    task automatic checkIdle(input string tag);
        checkOutput({tag, "_meas_ready"}, 32'(bus.meas_ready), 32'd1);
        checkOutput({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
        checkOutput({tag, "_pchidx"}, 32'(bus.pchidx), 32'd0);
    endtask

    // One full round with every patch active. meas_valid and result_ready
    // are pulsed mid-scan (and pch_basis inverted) to show they are ignored.
    // Leaves the DUT in DONE at a falling edge with result_ready low.
    task automatic runRound(input string tag, input logic [3:0] basis,
                            input logic [3:0] exp_res, input logic [3:0] exp_syn);
        applyStimulus(1'b1, basis, 1'b0);
        checkOutput({tag, "_accept_ready"}, 32'(bus.meas_ready), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            applyStimulus(c == 2, ~basis, c == 3);
            checkOutput($sformatf("%s_pchidx_c%0d", tag, c), 32'(bus.pchidx), 32'(c - 1));
            checkOutput($sformatf("%s_valid_c%0d", tag, c), 32'(bus.result_valid), 32'd0);
            checkOutput($sformatf("%s_ready_c%0d", tag, c), 32'(bus.meas_ready), 32'd0);
        end
        @(negedge clk);
        applyStimulus(1'b0, basis, 1'b0);
        checkOutput({tag, "_valid_c5"}, 32'(bus.result_valid), 32'd1);
        checkOutput({tag, "_result"}, 32'(bus.pchmeas_result), 32'(exp_res));
        checkOutput({tag, "_synflag"}, 32'(bus.pchsyn_flag), 32'(exp_syn));
    endtask

    task automatic finishRound(input string tag);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkIdle(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'b0000, 1'b0);
`ifdef LMU_PCHSKIP_EN
        bus.pch_active = 4'b1111;
`endif
        loadTables(16'h8730, 12'h400, 32'h00AA0100);

        // Reset and idle state
        @(negedge clk);
        checkIdle("rst");
        checkOutput("rst_result", 32'(bus.pchmeas_result), 32'd0);
        checkOutput("rst_synflag", 32'(bus.pchsyn_flag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkIdle("idle");
        checkOutput("idle_result", 32'(bus.pchmeas_result), 32'd0);

        // Round A: all Z basis; patch2 dq=0111 with only Z flips -> 1,
        // patch3 aq=010 is the only syndrome
        $display("[TB] round A: Z basis, scan order and latency");
        runRound("A", 4'b1111, 4'b1110, 4'b1000);
        finishRound("A_done");

        // Round B: patch1 X basis, dq=0001 with Z flip on dq0 -> 0
        $display("[TB] round B: patch1 in X basis");
        loadTables(16'h8710, 12'h044, 32'h00AA0200);
        runRound("B", 4'b1101, 4'b1100, 4'b0101);
        finishRound("B_done");

        // Round C: same frame, Z basis on patch1 -> 1; then hold results
        $display("[TB] round C: patch1 in Z basis, result hold");
        runRound("C", 4'b1111, 4'b1110, 4'b0101);
        for (int h = 0; h < 10; h++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_valid_%0d", h), 32'(bus.result_valid), 32'd1);
            checkOutput($sformatf("hold_result_%0d", h), 32'(bus.pchmeas_result), 32'h0000000E);
            checkOutput($sformatf("hold_syn_%0d", h), 32'(bus.pchsyn_flag), 32'h00000005);
            checkOutput($sformatf("hold_pchidx_%0d", h), 32'(bus.pchidx), 32'd3);
        end

        // Round D: meas_valid together with result_ready in DONE only
        // returns to IDLE; the new round is taken on the next cycle
        $display("[TB] round D: back-to-back accept after handshake");
        loadTables(16'h0710, 12'h000, 32'h00AA0200);
        applyStimulus(1'b1, 4'b1111, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        checkIdle("D_idle");
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            applyStimulus(1'b0, 4'b1111, 1'b0);
            checkOutput($sformatf("D_pchidx_c%0d", c), 32'(bus.pchidx), 32'(c - 1));
            checkOutput($sformatf("D_ready_c%0d", c), 32'(bus.meas_ready), 32'd0);
        end
        @(negedge clk);
        checkOutput("D_valid", 32'(bus.result_valid), 32'd1);
        checkOutput("D_result", 32'(bus.pchmeas_result), 32'h00000006);
        checkOutput("D_synflag", 32'(bus.pchsyn_flag), 32'd0);
        finishRound("D_done");

        // Reset asserted mid-scan at pchidx=2
        $display("[TB] reset during scan");
        loadTables(16'h8730, 12'h400, 32'h00AA0100);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            applyStimulus(1'b0, 4'b1111, 1'b0);
        end
        checkOutput("mid_pchidx", 32'(bus.pchidx), 32'd2);
        checkOutput("mid_result", 32'(bus.pchmeas_result), 32'h00000002);
        rst_n = 1'b0;
        #1;
        checkIdle("abort");
        checkOutput("abort_result", 32'(bus.pchmeas_result), 32'd0);
        checkOutput("abort_synflag", 32'(bus.pchsyn_flag), 32'd0);
        @(negedge clk);
        checkOutput("abort_hold_valid", 32'(bus.result_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        runRound("R", 4'b1111, 4'b1110, 4'b1000);
        finishRound("R_done");

`ifdef LMU_PCHSKIP_EN
        // Only patches 1 and 3 active
        $display("[TB] skip: mask 1010");
        bus.pch_active = 4'b1010;
        applyStimulus(1'b1, 4'b1111, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkOutput("skip_pchidx_1", 32'(bus.pchidx), 32'd1);
        checkOutput("skip_valid_1", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        checkOutput("skip_pchidx_2", 32'(bus.pchidx), 32'd3);
        checkOutput("skip_valid_2", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        checkOutput("skip_valid_3", 32'(bus.result_valid), 32'd1);
        checkOutput("skip_result", 32'(bus.pchmeas_result), 32'h0000000A);
        checkOutput("skip_synflag", 32'(bus.pchsyn_flag), 32'h00000008);
        finishRound("skip_done");

        // Empty mask goes straight to DONE with all-zero results
        $display("[TB] skip: empty mask");
        bus.pch_active = 4'b0000;
        applyStimulus(1'b1, 4'b1111, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkOutput("empty_valid", 32'(bus.result_valid), 32'd1);
        checkOutput("empty_ready", 32'(bus.meas_ready), 32'd0);
        checkOutput("empty_result", 32'(bus.pchmeas_result), 32'd0);
        checkOutput("empty_synflag", 32'(bus.pchsyn_flag), 32'd0);
        finishRound("empty_done");
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
